// File: rtl/uart_rx_fifo.sv
// Parametrised UART receiver with start-bit glitch rejection, optional parity,
// frame/parity/overflow error pulses and a first-word fall-through receive FIFO.
module uart_rx_fifo #(
    parameter int unsigned BAUD_COUNT = 645,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          rx_in,
    output logic [DATA_BITS-1:0]          data_out,
    output logic                          valid_out,
    input  logic                          ready_in,
    output logic [$clog2(FIFO_DEPTH):0]   count_out,
    output logic                          full_out,
    output logic                          frame_err_out,
    output logic                          parity_err_out,
    output logic                          overflow_out
);

    localparam int unsigned CNT_W = $clog2(BAUD_COUNT);
    localparam int unsigned IDX_W = $clog2(DATA_BITS);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BAUD_COUNT / 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_COUNT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);
    localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
    localparam logic [OCC_W-1:0] OCC_ZERO = OCC_W'(0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    // Receiver state
    logic                 r_rx_meta;
    logic                 r_rx_s;
    logic                 r_rx_prev;
    state_t               r_state;
    state_t               w_state_next;
    logic [CNT_W-1:0]     r_cnt;
    logic [IDX_W-1:0]     r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_err;

    // FSM decode strobes
    logic                 w_at_last;
    logic                 w_shift_en;
    logic                 w_par_chk;
    logic                 w_push;
    logic                 w_frame_err;
    logic                 w_parity_err;
    logic                 w_par_xor;
    logic                 w_par_bad;

    // FIFO state
    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [PTR_W-1:0]     w_rd_ptr_inc;
    logic [OCC_W-1:0]     r_count;
    logic [OCC_W-1:0]     w_count_next;
    logic [DATA_BITS-1:0] r_head;
    logic [DATA_BITS-1:0] w_head_next;
    logic                 r_valid;
    logic                 r_full;
    logic                 w_pop;
    logic                 w_wr_en;
    logic                 w_overflow;

    // Error pulse registers
    logic                 r_frame_err;
    logic                 r_parity_err;
    logic                 r_overflow;

    assign w_at_last    = (r_cnt == CNT_LAST);
    assign w_par_xor    = (^r_shift) ^ r_rx_s;
    assign w_par_bad    = (PARITY == 1) ? ~w_par_xor : w_par_xor;
    assign w_pop        = r_valid & ready_in;
    assign w_wr_en      = w_push & (~r_full | w_pop);
    assign w_overflow   = w_push & r_full & ~w_pop;
    assign w_rd_ptr_inc = r_rd_ptr + PTR_W'(1);

    // Two-flop synchroniser plus one history flop for start-edge detection
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rx_in;
            r_rx_s    <= r_rx_meta;
            r_rx_prev <= r_rx_s;
        end
    end

    // FSM state register
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state and per-cycle action strobes
    always_comb begin
        w_state_next = r_state;
        w_shift_en   = 1'b0;
        w_par_chk    = 1'b0;
        w_push       = 1'b0;
        w_frame_err  = 1'b0;
        w_parity_err = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_rx_prev && !r_rx_s) begin
                    w_state_next = S_START;
                end
            end
            S_START: begin
                if (r_cnt == CNT_HALF) begin
                    w_state_next = r_rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (w_at_last) begin
                    w_shift_en = 1'b1;
                    if (r_bit_idx == IDX_LAST) begin
                        w_state_next = (PARITY != 0) ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (w_at_last) begin
                    w_par_chk    = 1'b1;
                    w_state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (w_at_last) begin
                    if (!r_rx_s) begin
                        w_frame_err  = 1'b1;
                        w_state_next = S_BREAK;
                    end else if (r_par_err) begin
                        w_parity_err = 1'b1;
                        w_state_next = S_IDLE;
                    end else begin
                        w_push       = 1'b1;
                        w_state_next = S_IDLE;
                    end
                end
            end
            S_BREAK: begin
                if (r_rx_s) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Bit timer: free-runs within a bit, restarts on every state change
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_cnt <= '0;
        end else if (w_state_next != r_state) begin
            r_cnt <= '0;
        end else if (w_at_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Data shift register, bit index and latched parity error
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_par_err <= 1'b0;
        end else begin
            if (r_state != S_DATA) begin
                r_bit_idx <= '0;
            end else if (w_shift_en) begin
                r_bit_idx <= r_bit_idx + IDX_W'(1);
            end
            if (w_shift_en) begin
                r_shift[r_bit_idx] <= r_rx_s;
            end
            if (r_state == S_IDLE) begin
                r_par_err <= 1'b0;
            end else if (w_par_chk && w_par_bad) begin
                r_par_err <= 1'b1;
            end
        end
    end

    // Next occupancy and next head word for the registered FIFO outputs
    always_comb begin
        w_count_next = r_count;
        w_head_next  = r_head;
        case ({w_wr_en, w_pop})
            2'b10:   w_count_next = r_count + OCC_ONE;
            2'b01:   w_count_next = r_count - OCC_ONE;
            default: w_count_next = r_count;
        endcase
        if (w_pop) begin
            if (r_count == OCC_ONE) begin
                if (w_wr_en) begin
                    w_head_next = r_shift;
                end
            end else begin
                w_head_next = r_mem[w_rd_ptr_inc];
            end
        end else if ((r_count == OCC_ZERO) && w_wr_en) begin
            w_head_next = r_shift;
        end
    end

    // FIFO storage array (no reset needed: reads are gated by occupancy)
    always_ff @(posedge clk_in) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= r_shift;
        end
    end

    // FIFO pointers, occupancy and registered head/flags
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
            r_valid  <= 1'b0;
            r_full   <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_ptr_inc;
            end
            r_count <= w_count_next;
            r_head  <= w_head_next;
            r_valid <= (w_count_next != OCC_ZERO);
            r_full  <= (w_count_next == OCC_FULL);
        end
    end

    // Single-cycle error pulses
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_frame_err  <= w_frame_err;
            r_parity_err <= w_parity_err;
            r_overflow   <= w_overflow;
        end
    end

    assign data_out       = r_head;
    assign valid_out      = r_valid;
    assign count_out      = r_count;
    assign full_out       = r_full;
    assign frame_err_out  = r_frame_err;
    assign parity_err_out = r_parity_err;
    assign overflow_out   = r_overflow;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: one no-parity and one even-parity instance.
module tb_uart_rx_fifo;

    logic       clk;
    logic       rst;
    logic       rx0, rx2;
    logic       ready0, ready2;
    logic [7:0] data0, data2;
    logic       valid0, valid2;
    logic [2:0] count0, count2;
    logic       full0, full2;
    logic       fe0, fe2, pe0, pe2, ovf0, ovf2;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int frame_t0 = 0;

    logic [7:0] q0[$];
    logic [7:0] q2[$];

    int vcyc0 = 0, vcyc2 = 0;
    int rise0 = 0;
    logic pv0 = 1'b0;
    int nfe0 = 0, nfe2 = 0, npe0 = 0, npe2 = 0, novf0 = 0, novf2 = 0;

    uart_rx_fifo #(.BAUD_COUNT(16), .DATA_BITS(8), .PARITY(0), .FIFO_DEPTH(4)) u_dut0 (
        .clk_in(clk), .rst_in(rst), .rx_in(rx0),
        .data_out(data0), .valid_out(valid0), .ready_in(ready0),
        .count_out(count0), .full_out(full0),
        .frame_err_out(fe0), .parity_err_out(pe0), .overflow_out(ovf0)
    );

    uart_rx_fifo #(.BAUD_COUNT(16), .DATA_BITS(8), .PARITY(2), .FIFO_DEPTH(4)) u_dut2 (
        .clk_in(clk), .rst_in(rst), .rx_in(rx2),
        .data_out(data2), .valid_out(valid2), .ready_in(ready2),
        .count_out(count2), .full_out(full2),
        .frame_err_out(fe2), .parity_err_out(pe2), .overflow_out(ovf2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever a word is handed over, tallies pulses
    always @(negedge clk) begin
        logic [7:0] exp_w;
        if (!rst) begin
            if (valid0 && ready0) begin
                if (q0.size() == 0) begin
                    n_checks++;
                    $display("FAIL dut0_word: got 0x%0h, expected no word", data0);
                end else begin
                    exp_w = q0.pop_front();
                    check("dut0_word", int'(data0), int'(exp_w));
                end
            end
            if (valid2 && ready2) begin
                if (q2.size() == 0) begin
                    n_checks++;
                    $display("FAIL dut2_word: got 0x%0h, expected no word", data2);
                end else begin
                    exp_w = q2.pop_front();
                    check("dut2_word", int'(data2), int'(exp_w));
                end
            end
            if (valid0) vcyc0++;
            if (valid2) vcyc2++;
            if (valid0 && !pv0) rise0 = cyc;
            pv0 = valid0;
            if (fe0)  nfe0++;
            if (fe2)  nfe2++;
            if (pe0)  npe0++;
            if (pe2)  npe2++;
            if (ovf0) novf0++;
            if (ovf2) novf2++;
        end else begin
            pv0 = 1'b0;
        end
    end

    task automatic drive(input int which, input logic v);
        if (which == 0) rx0 = v;
        else            rx2 = v;
    endtask

    task automatic bit_out(input int which, input logic v, input int n);
        drive(which, v);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Sends start, 8 data bits LSB first, optional parity, then stop (or 40-cycle low)
    task automatic send_frame(input int which, input logic [7:0] d, input bit has_par,
                              input logic p, input bit bad_stop);
        @(posedge clk);
        #1;
        frame_t0 = cyc;
        bit_out(which, 1'b0, 16);
        for (int i = 0; i < 8; i++) bit_out(which, d[i], 16);
        if (has_par) bit_out(which, p, 16);
        if (bad_stop) begin
            bit_out(which, 1'b0, 40);
            drive(which, 1'b1);
        end else begin
            bit_out(which, 1'b1, 16);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int vb;
        rst = 1'b1; rx0 = 1'b1; rx2 = 1'b1; ready0 = 1'b0; ready2 = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("rst_valid0", int'(valid0), 0);
        check("rst_count0", int'(count0), 0);
        check("rst_full0",  int'(full0),  0);
        check("rst_data0",  int'(data0),  0);
        check("rst_pulses0", int'({fe0, pe0, ovf0}), 0);
        check("rst_valid2", int'(valid2), 0);
        @(posedge clk); #1 rst = 1'b0;
        idle(5);

        // 1: plain 8N1 word with consumer ready
        ready0 = 1'b1;
        ready2 = 1'b1;
        vb = vcyc0;
        q0.push_back(8'hA5);
        send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b0);
        idle(10);
        @(negedge clk);
        check("t1_latency", rise0 - frame_t0, 156);
        check("t1_valid_cycles", vcyc0 - vb, 1);
        check("t1_count0", int'(count0), 0);
        check("t1_queue0", q0.size(), 0);

        // 2: even parity, good then bad parity bit
        vb = vcyc2;
        q2.push_back(8'h07);
        send_frame(1, 8'h07, 1'b1, 1'b1, 1'b0);
        idle(20);
        send_frame(1, 8'h07, 1'b1, 1'b0, 1'b0);
        idle(20);
        @(negedge clk);
        check("t2_parity_err", npe2, 1);
        check("t2_frame_err", nfe2, 0);
        check("t2_count2", int'(count2), 0);
        check("t2_words", vcyc2 - vb, 1);
        check("t2_queue2", q2.size(), 0);

        // 3: short low glitch on an idle line
        vb = vcyc0;
        @(posedge clk); #1 rx0 = 1'b0;
        idle(5);
        rx0 = 1'b1;
        idle(200);
        @(negedge clk);
        check("t3_no_word", vcyc0 - vb, 0);
        check("t3_no_frame_err", nfe0, 0);
        check("t3_count0", int'(count0), 0);

        // 4: low stop bit held as a break, then a good word
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1);
        idle(20);
        @(negedge clk);
        check("t4_frame_err", nfe0, 1);
        check("t4_count0", int'(count0), 0);
        q0.push_back(8'h11);
        send_frame(0, 8'h11, 1'b0, 1'b0, 1'b0);
        idle(10);
        @(negedge clk);
        check("t4_queue0", q0.size(), 0);
        check("t4_frame_err_once", nfe0, 1);

        // 5: fill the FIFO with consumer stalled, overflow, then drain
        ready0 = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            logic [7:0] w;
            w = 8'(i);
            if (i <= 4) q0.push_back(w);
            send_frame(0, w, 1'b0, 1'b0, 1'b0);
            if (i == 3) begin
                @(negedge clk);
                check("t5_full_at3", int'(full0), 0);
            end
            if (i == 4) begin
                @(negedge clk);
                check("t5_full_at4", int'(full0), 1);
                check("t5_count_at4", int'(count0), 4);
                check("t5_no_ovf_yet", novf0, 0);
            end
        end
        idle(4);
        @(negedge clk);
        check("t5_overflow", novf0, 1);
        check("t5_count_after_ovf", int'(count0), 4);
        check("t5_head", int'(data0), 1);
        @(posedge clk); #1 ready0 = 1'b1;
        idle(10);
        @(negedge clk);
        check("t5_drained_queue", q0.size(), 0);
        check("t5_count_drained", int'(count0), 0);
        check("t5_full_drained", int'(full0), 0);

        // 6: reset in the middle of data bit 3
        vb = vcyc0;
        fork
            send_frame(0, 8'hFF, 1'b0, 1'b0, 1'b0);
            begin
                repeat (71) @(posedge clk);
                #1 rst = 1'b1;
                @(posedge clk);
                @(negedge clk);
                check("t6_rst_valid0", int'(valid0), 0);
                check("t6_rst_count0", int'(count0), 0);
                check("t6_rst_data0",  int'(data0),  0);
                check("t6_rst_data2",  int'(data2),  0);
                check("t6_rst_pulses", int'({fe0, pe0, ovf0}), 0);
                @(posedge clk); #1 rst = 1'b0;
            end
        join
        idle(50);
        @(negedge clk);
        check("t6_no_push", vcyc0 - vb, 0);
        check("t6_count0", int'(count0), 0);
        q0.push_back(8'h5A);
        send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b0);
        idle(10);
        @(negedge clk);
        check("t6_queue0", q0.size(), 0);

        // Totals of stray pulses across the run
        check("tot_parity_err0", npe0, 0);
        check("tot_overflow2", novf2, 0);
        check("tot_frame_err2", nfe2, 0);
        check("tot_overflow0", novf0, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
